// File: rtl/lane_judge_pkg.sv
// Shared types and scoring constants for the lane judge / score counter.
package lane_judge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        GOOD = 2'd1,
        PERF = 2'd2
    } grade_t;

    localparam int MULT_CAP = 4;
    localparam int PTS_PERF = 3;
    localparam int PTS_GOOD = 1;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for one raw button followed by a rising-edge detector.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign press = sync_p1 & ~prev_p2;

endmodule

// File: rtl/lane_judge_scorer.sv
// Per-lane hit/miss judge with combo-multiplied scoring for the note shifter.
// Optional per-song grade counters when JUDGE_STATS_EN is defined.
module lane_judge_scorer
    import lane_judge_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int OFFSET_W  = 3,
    parameter int PERF_LO   = 2,
    parameter int PERF_HI   = 5,
    parameter int SCORE_W   = 16,
    parameter int COMBO_W   = 8,
    parameter int MULT_STEP = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                finish,
    input  logic [LANES-1:0]    btn,
    input  logic [LANES-1:0]    note_at_judge,
    input  logic                note_advance,
    input  logic [OFFSET_W-1:0] offset,
    output logic [LANES-1:0]    delete,
    output logic [LANES-1:0]    grade_perf,
    output logic [LANES-1:0]    grade_good,
    output logic [LANES-1:0]    miss,
    output logic [SCORE_W-1:0]  score,
    output logic [COMBO_W-1:0]  combo,
    output logic [COMBO_W-1:0]  max_combo,
    output logic                playing
`ifdef JUDGE_STATS_EN
    ,
    output logic [COMBO_W+3:0]  n_perf,
    output logic [COMBO_W+3:0]  n_good,
    output logic [COMBO_W+3:0]  n_miss
`endif
);

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (a + b > lim) ? lim : a + b;
    endfunction

    state_t               state, state_next;
    grade_t               grade;
    logic [LANES-1:0]     press, consumed, hit, miss_c, perf_mask;
    logic                 active;
    int                   n_pf, n_gd, n_ms, mult, pts;
    logic [SCORE_W-1:0]   score_next;
    logic [COMBO_W-1:0]   combo_next, max_next;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        btn_edge_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .press (press[i])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PLAY;
            PLAY:    if (start) state_next = PLAY;
                     else if (finish) state_next = DONE;
            DONE:    if (start) state_next = PLAY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    assign playing = (state == PLAY);

    // Judge stage: a start cycle re-enters PLAY, so nothing is judged in it.
    always_comb begin
        active    = (state == PLAY) && !start;
        grade     = (int'(offset) >= PERF_LO && int'(offset) <= PERF_HI) ? PERF : GOOD;
        hit       = press & note_at_judge & ~consumed & {LANES{active}};
        miss_c    = note_at_judge & ~consumed & ~hit & {LANES{active & note_advance}};
        perf_mask = (grade == PERF) ? hit : '0;
        n_pf = 0;
        n_gd = 0;
        n_ms = 0;
        for (int i = 0; i < LANES; i++) begin
            if (hit[i] && grade == PERF) n_pf = n_pf + 1;
            if (hit[i] && grade != PERF) n_gd = n_gd + 1;
            if (miss_c[i])               n_ms = n_ms + 1;
        end
        mult = int'(combo) / MULT_STEP + 1;
        if (mult > MULT_CAP) mult = MULT_CAP;
        pts        = mult * (n_pf * PTS_PERF + n_gd * PTS_GOOD);
        score_next = SCORE_W'(sat_add(longint'(score), longint'(pts), SCORE_W));
        combo_next = (n_ms != 0) ? '0
                   : COMBO_W'(sat_add(longint'(combo), longint'(n_pf + n_gd), COMBO_W));
        max_next   = (combo_next > max_combo) ? combo_next : max_combo;
    end

    // Result stage: registered pulses and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delete     <= '0;
            grade_perf <= '0;
            grade_good <= '0;
            miss       <= '0;
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
            consumed   <= '0;
        end else begin
            delete     <= hit;
            grade_perf <= perf_mask;
            grade_good <= hit & ~perf_mask;
            miss       <= miss_c;
            if (start) begin
                score     <= '0;
                combo     <= '0;
                max_combo <= '0;
                consumed  <= '0;
            end else if (state == PLAY) begin
                score     <= score_next;
                combo     <= combo_next;
                max_combo <= max_next;
                consumed  <= note_advance ? '0 : (consumed | hit);
            end
        end
    end

`ifdef JUDGE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_perf <= '0;
            n_good <= '0;
            n_miss <= '0;
        end else if (start) begin
            n_perf <= '0;
            n_good <= '0;
            n_miss <= '0;
        end else if (state == PLAY) begin
            n_perf <= (COMBO_W+4)'(sat_add(longint'(n_perf), longint'(n_pf), COMBO_W + 4));
            n_good <= (COMBO_W+4)'(sat_add(longint'(n_good), longint'(n_gd), COMBO_W + 4));
            n_miss <= (COMBO_W+4)'(sat_add(longint'(n_miss), longint'(n_ms), COMBO_W + 4));
        end
    end
`endif

endmodule

// File: tb/tb_lane_judge_scorer.sv
// Randomised and directed bench for lane_judge_scorer against a cycle-level score model.
module tb_lane_judge_scorer;

    localparam int LANES     = 2;
    localparam int OFFSET_W  = 3;
    localparam int PERF_LO   = 2;
    localparam int PERF_HI   = 5;
    localparam int SCORE_W   = 9;
    localparam int COMBO_W   = 5;
    localparam int MULT_STEP = 10;
    localparam int SMAX      = (1 << SCORE_W) - 1;
    localparam int CMAX      = (1 << COMBO_W) - 1;
    localparam int STMAX     = (1 << (COMBO_W + 4)) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start, finish, note_advance;
    logic [LANES-1:0]    btn, note_at_judge;
    logic [OFFSET_W-1:0] offset;
    logic [LANES-1:0]    delete, grade_perf, grade_good, miss;
    logic [SCORE_W-1:0]  score;
    logic [COMBO_W-1:0]  combo, max_combo;
    logic                playing;
`ifdef JUDGE_STATS_EN
    logic [COMBO_W+3:0]  n_perf, n_good, n_miss;
`endif

    always #5 clk = ~clk;

    lane_judge_scorer #(
        .LANES(LANES), .OFFSET_W(OFFSET_W), .PERF_LO(PERF_LO), .PERF_HI(PERF_HI),
        .SCORE_W(SCORE_W), .COMBO_W(COMBO_W), .MULT_STEP(MULT_STEP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .btn(btn),
        .note_at_judge(note_at_judge), .note_advance(note_advance), .offset(offset),
        .delete(delete), .grade_perf(grade_perf), .grade_good(grade_good), .miss(miss),
        .score(score), .combo(combo), .max_combo(max_combo), .playing(playing)
`ifdef JUDGE_STATS_EN
        , .n_perf(n_perf), .n_good(n_good), .n_miss(n_miss)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: game mode 0=idle 1=play 2=done; btn seen by judge two samples late.
    int           md, m_score, m_combo, m_max, s_perf, s_good, s_miss;
    bit [LANES-1:0] m_cons, hist0, hist1, hist2;
    bit [LANES-1:0] e_del, e_perf, e_good, e_miss;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        md = 0; m_score = 0; m_combo = 0; m_max = 0;
        s_perf = 0; s_good = 0; s_miss = 0;
        m_cons = '0; hist0 = '0; hist1 = '0; hist2 = '0;
        e_del = '0; e_perf = '0; e_good = '0; e_miss = '0;
    endtask

    task automatic model_edge();
        bit [LANES-1:0] pr;
        bit act, anymiss;
        int m, pts, nh;
        pr = hist1 & ~hist2;
        hist2 = hist1; hist1 = hist0; hist0 = btn;
        act = (md == 1) && !start;
        e_del = '0; e_perf = '0; e_good = '0; e_miss = '0;
        m = imin(1 + m_combo / MULT_STEP, 4);
        pts = 0; nh = 0; anymiss = 0;
        for (int i = 0; i < LANES; i++) begin
            if (act && pr[i] && note_at_judge[i] && !m_cons[i]) begin
                e_del[i] = 1'b1;
                nh++;
                if (int'(offset) >= PERF_LO && int'(offset) <= PERF_HI) begin
                    e_perf[i] = 1'b1; pts += 3 * m; s_perf = imin(s_perf + 1, STMAX);
                end else begin
                    e_good[i] = 1'b1; pts += m; s_good = imin(s_good + 1, STMAX);
                end
            end else if (act && note_advance && note_at_judge[i] && !m_cons[i]) begin
                e_miss[i] = 1'b1; anymiss = 1'b1; s_miss = imin(s_miss + 1, STMAX);
            end
        end
        if (start) begin
            md = 1; m_score = 0; m_combo = 0; m_max = 0; m_cons = '0;
            s_perf = 0; s_good = 0; s_miss = 0;
        end else if (md == 1) begin
            m_score = imin(m_score + pts, SMAX);
            m_combo = anymiss ? 0 : imin(m_combo + nh, CMAX);
            if (m_combo > m_max) m_max = m_combo;
            m_cons = note_advance ? '0 : (m_cons | e_del);
            if (finish) md = 2;
        end
    endtask

    task automatic cmp_outputs();
        check("delete", delete, e_del);
        check("grade_perf", grade_perf, e_perf);
        check("grade_good", grade_good, e_good);
        check("miss", miss, e_miss);
        check("score", score, m_score);
        check("combo", combo, m_combo);
        check("max_combo", max_combo, m_max);
        check("playing", playing, (md == 1));
`ifdef JUDGE_STATS_EN
        check("n_perf", n_perf, s_perf);
        check("n_good", n_good, s_good);
        check("n_miss", n_miss, s_miss);
`endif
    endtask

    task automatic cyc(input logic [LANES-1:0] b, input logic [LANES-1:0] n,
                       input logic [OFFSET_W-1:0] o, input logic a, input logic s, input logic f);
        btn = b; note_at_judge = n; offset = o; note_advance = a; start = s; finish = f;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_outputs();
    endtask

    // One double hit: press both lanes, judged two cycles later, note retired after.
    task automatic double_hit(input logic adv_with_hit);
        cyc(2'b11, 2'b11, 3, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 2'b11, 3, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 2'b11, 3, adv_with_hit, 1'b0, 1'b0);
        cyc(2'b00, 2'b11, 3, !adv_with_hit, 1'b0, 1'b0);
    endtask

    initial begin
        logic [LANES-1:0] rb;
        rst = 1'b0; start = 0; finish = 0; note_advance = 0;
        btn = '0; note_at_judge = '0; offset = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        cmp_outputs();
        check("rst_state_playing", playing, 0);
        rst = 1'b1;

        cyc(2'b00, 2'b00, 0, 0, 1, 0);
        cyc(2'b01, 2'b01, 3, 0, 0, 0);
        cyc(2'b01, 2'b01, 3, 0, 0, 0);
        cyc(2'b01, 2'b01, 3, 0, 0, 0);
        check("perf_delete", delete, 2'b01);
        check("perf_grade", grade_perf, 2'b01);
        check("perf_score", score, 3);
        check("perf_combo", combo, 1);
        cyc(2'b00, 2'b01, 3, 1, 0, 0);
        check("consumed_no_miss", miss, 2'b00);

        cyc(2'b01, 2'b01, 7, 0, 0, 0);
        cyc(2'b01, 2'b01, 7, 0, 0, 0);
        cyc(2'b01, 2'b01, 7, 0, 0, 0);
        check("good_grade", grade_good, 2'b01);
        check("good_score", score, 4);
        cyc(2'b00, 2'b01, 7, 1, 0, 0);

        for (int k = 0; k < 3; k++) cyc(2'b01, 2'b00, 3, 0, 0, 0);
        check("whiff_score", score, 4);
        check("whiff_delete", delete, 2'b00);
        cyc(2'b00, 2'b00, 3, 0, 0, 0);

        cyc(2'b00, 2'b10, 3, 1, 0, 0);
        check("miss_lane1", miss, 2'b10);
        check("miss_combo", combo, 0);
        check("miss_max_hold", max_combo, 2);

        for (int k = 0; k < 6; k++) double_hit(k[0]);
        check("mult2_score", score, 46);
        check("mult2_combo", combo, 12);
        for (int k = 0; k < 30; k++) double_hit(k[0]);
        check("score_sat", score, SMAX);
        check("combo_sat", combo, CMAX);
        check("max_sat", max_combo, CMAX);

        cyc(2'b00, 2'b10, 3, 1, 0, 0);
        check("sat_miss_combo", combo, 0);
        check("sat_miss_max", max_combo, CMAX);

        cyc(2'b00, 2'b00, 3, 0, 0, 1);
        check("done_playing", playing, 0);
        for (int k = 0; k < 2; k++) double_hit(1'b0);
        check("done_score_hold", score, SMAX);
        cyc(2'b00, 2'b00, 3, 0, 1, 0);
        check("restart_score", score, 0);
        check("restart_max", max_combo, 0);

        rb = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < LANES; i++)
                if ($urandom_range(0, 9) < 3) rb[i] = ~rb[i];
            cyc(rb, LANES'($urandom), OFFSET_W'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 149) == 0));
        end

        cyc(2'b00, 2'b00, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) double_hit(k[0]);
        rst = 1'b0;
        #1;
        check("async_rst_score", score, 0);
        check("async_rst_combo", combo, 0);
        check("async_rst_max", max_combo, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_delete", delete, 0);
        model_reset();
        #1 rst = 1'b1;
        cyc(2'b00, 2'b00, 0, 0, 1, 0);
        check("post_rst_playing", playing, 1);
        check("post_rst_score", score, 0);
        double_hit(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
